// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Bit time is prescale clocks (4/8/16/32, anything else means 8), matching the oversampling receiver.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [4:0]            edge_cnt_reg, edge_cnt_next;
  logic [4:0]            last_reg, last_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  end_of_bit;
  logic                  parity_bit;
  logic [4:0]            last_decoded;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      edge_cnt_reg <= '0;
      last_reg     <= 5'd7;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      last_reg     <= last_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      par_en_reg   <= par_en_next;
      par_typ_reg  <= par_typ_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
    end
  end

  // Bit time is held as P-1 so end-of-bit is a single compare against the counter.
  always_comb begin
    case (prescale)
      6'd4:    last_decoded = 5'd3;
      6'd16:   last_decoded = 5'd15;
      6'd32:   last_decoded = 5'd31;
      default: last_decoded = 5'd7;
    endcase
  end

  assign end_of_bit = (edge_cnt_reg == last_reg);
  assign parity_bit = (^data_reg) ^ par_typ_reg;

  always_comb begin
    state_next    = state_reg;
    edge_cnt_next = edge_cnt_reg;
    last_next     = last_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    par_en_next   = par_en_reg;
    par_typ_next  = par_typ_reg;

    if (state_reg != IDLE) begin
      edge_cnt_next = end_of_bit ? 5'd0 : edge_cnt_reg + 5'd1;
    end

    case (state_reg)
      IDLE: begin
        if (data_valid) begin
          state_next    = START;
          data_next     = p_data;
          par_en_next   = par_en;
          par_typ_next  = par_typ;
          last_next     = last_decoded;
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end
      START: begin
        if (end_of_bit) state_next = DATA;
      end
      DATA: begin
        if (end_of_bit) begin
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (end_of_bit) state_next = STOP;
      end
      STOP: begin
        if (end_of_bit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so the line flop changes on the same edge as the FSM.
    tx_next   = 1'b1;
    busy_next = 1'b1;
    case (state_next)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_next[bit_cnt_next];
      PARITY:  tx_next = parity_bit;
      STOP:    tx_next = 1'b1;
      default: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus random frames compared
// cycle by cycle against a frame-level model of the serial waveform.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bit_time(input logic [5:0] ps);
    if (ps == 6'd4 || ps == 6'd8 || ps == 6'd16 || ps == 6'd32) return int'(ps);
    return 8;
  endfunction

  // Line levels of a whole frame, one entry per bit.
  function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt,
                                      output logic bits[$]);
    int ones;
    bits = {};
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
    bits.push_back(1'b1);
  endfunction

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check($sformatf("%s_tx[%0d]", tag, i), tx_out, 1'b1);
      check($sformatf("%s_busy[%0d]", tag, i), busy, 1'b0);
    end
  endtask

  // Called at a negedge. Requests a frame, then checks every cycle of it.
  // disturb: cycle index at which conflicting inputs are pulsed (-1 = none).
  // abort:   cycle index at which reset is asserted mid-frame (-1 = none).
  // hold:    keep data_valid high through the frame.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] ps, input int disturb, input int abort,
                           input bit hold);
    logic bits[$];
    int   p;
    int   n;
    build_frame(d, pe, pt, bits);
    p = bit_time(ps);
    n = bits.size() * p;
    $display("frame data=%02h par_en=%0d par_typ=%0d prescale=%0d bit_time=%0d cycles=%0d",
             d, pe, pt, ps, p, n);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    @(posedge CLK);
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      if (j == 0 && !hold) data_valid = 1'b0;
      check($sformatf("d%02h_tx[%0d]", d, j), tx_out, bits[j / p]);
      check($sformatf("d%02h_busy[%0d]", d, j), busy, 1'b1);
      if (j == disturb) begin
        data_valid = 1'b1;
        p_data     = ~d;
        par_en     = ~pe;
        par_typ    = ~pt;
        prescale   = 6'd4;
      end else if (j == disturb + 1) begin
        data_valid = 1'b0;
      end
      if (j == abort) begin
        #2 RST = 1'b0;
        #1;
        check("reset_mid_tx", tx_out, 1'b1);
        check("reset_mid_busy", busy, 1'b0);
        @(negedge CLK);
        check("reset_hold_tx", tx_out, 1'b1);
        check("reset_hold_busy", busy, 1'b0);
        RST = 1'b1;
        return;
      end
    end
    @(negedge CLK);
    check($sformatf("d%02h_end_tx", d), tx_out, 1'b1);
    check($sformatf("d%02h_end_busy", d), busy, 1'b0);
  endtask

  initial begin
    logic [5:0] ps_tab [4];
    logic [5:0] ps;
    ps_tab[0] = 6'd4;
    ps_tab[1] = 6'd8;
    ps_tab[2] = 6'd16;
    ps_tab[3] = 6'd32;

    RST        = 1'b0;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd8;
    repeat (3) @(negedge CLK);
    check("reset_tx", tx_out, 1'b1);
    check("reset_busy", busy, 1'b0);
    RST = 1'b1;
    idle_check(100, "post_reset");

    run_frame(8'hA5, 1'b0, 1'b0, 6'd8, -1, -1, 1'b0);
    idle_check(3, "gap");
    run_frame(8'hA5, 1'b1, 1'b0, 6'd8, -1, -1, 1'b0);
    idle_check(2, "gap");
    run_frame(8'hA5, 1'b1, 1'b1, 6'd8, -1, -1, 1'b0);
    idle_check(2, "gap");

    run_frame(8'h3C, 1'b0, 1'b0, 6'd4, -1, -1, 1'b0);
    idle_check(1, "gap");
    run_frame(8'h3C, 1'b0, 1'b0, 6'd16, -1, -1, 1'b0);
    idle_check(1, "gap");
    run_frame(8'h3C, 1'b1, 1'b1, 6'd32, -1, -1, 1'b0);
    idle_check(1, "gap");
    run_frame(8'h3C, 1'b0, 1'b0, 6'd5, -1, -1, 1'b0);
    idle_check(2, "gap");

    // Conflicting request mid-frame must neither corrupt nor queue.
    run_frame(8'h00, 1'b0, 1'b0, 6'd8, 37, -1, 1'b0);
    idle_check(20, "no_queue");

    // Back-to-back with data_valid held: exactly one idle cycle between frames.
    run_frame(8'h81, 1'b0, 1'b0, 6'd4, -1, -1, 1'b1);
    run_frame(8'h7E, 1'b1, 1'b0, 6'd4, -1, -1, 1'b0);
    idle_check(2, "gap");

    // Reset during data bit 3 (frame bit 4), then a clean frame.
    run_frame(8'h5A, 1'b1, 1'b0, 6'd8, -1, 4 * 8 + 3, 1'b0);
    idle_check(5, "after_reset");
    run_frame(8'h5A, 1'b1, 1'b0, 6'd8, -1, -1, 1'b0);
    idle_check(1, "gap");

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 4) == 0) ps = 6'($urandom_range(0, 63));
      else ps = ps_tab[$urandom_range(0, 3)];
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), ps, -1, -1, 1'b0);
      idle_check(int'($urandom_range(0, 3)), "rand_gap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
